altram_ctrl_mw: RTL and testbench



---
 rtl/altram_pkg.sv | 28 ++
 rtl/altram_ctrl_mw_clk_switch.sv | 109 ++++++++++
 rtl/altram_ctrl_mw.sv | 182 ++++++++++++++++++
 tb/tb_altram_ctrl_mw.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/altram_pkg.sv
// Shared types and constants for the alt-RAM accelerator glue.
// Bus/clock FSM encodings and command opcodes.
package altram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SDRAM,
    CTRL,
    PASS,
    HOLD
  } bus_st_t;

  typedef enum logic [1:0] {
    FAST,
    TO_SLOW,
    SLOWST,
    TO_FAST
  } clk_st_t;

  localparam logic [2:0] CMD_SHADOW = 3'd7;
  localparam logic [2:0] CMD_FAST   = 3'd6;
  localparam logic [2:0] CMD_SLOW   = 3'd5;

  localparam logic [19:0] CTRL_BASE_DEF = 20'hFFFE0;
  localparam logic [3:0]  ROM_BANK_DEF  = 4'hB;

endpackage

// File: rtl/altram_ctrl_mw_clk_switch.sv
// Glitch-free CPU clock mux: divided CLKOSC or synchronised CLK8.
// Hand-over parks CLKOUT low and resumes on a falling edge of the target.
module clk_switch
  import altram_pkg::*;
#(
  parameter int FAST_DIV    = 2,
  parameter int SYNC_STAGES = 3
) (
  input  logic CLKOSC,
  input  logic RST,
  input  logic CLK8,
  input  logic want_slow,
  output logic CLKOUT,
  output logic SLOW
);

  localparam logic [2:0] DIV_LAST = 3'(FAST_DIV - 1);

  logic [2:0]             div_cnt;
  logic                   fclk;
  logic                   fclk_d;
  logic [SYNC_STAGES-1:0] c8_sync;
  logic                   c8s;
  logic                   c8_d;
  logic                   fclk_fall;
  logic                   c8_fall;
  clk_st_t                st;
  clk_st_t                st_nx;
  logic                   clk_q;
  logic                   clk_nx;
  logic                   slow_q;

  assign c8s       = c8_sync[SYNC_STAGES-1];
  assign fclk_fall = fclk_d & ~fclk;
  assign c8_fall   = c8_d & ~c8s;

  // Fast clock divider, toggling every FAST_DIV cycles
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      div_cnt <= '0;
      fclk    <= 1'b0;
      fclk_d  <= 1'b0;
    end else begin
      fclk_d <= fclk;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        fclk    <= ~fclk;
      end else begin
        div_cnt <= div_cnt + 3'd1;
      end
    end
  end

  // CLK8 synchroniser plus edge history
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      c8_sync <= '0;
      c8_d    <= 1'b0;
    end else begin
      c8_sync <= {c8_sync[SYNC_STAGES-2:0], CLK8};
      c8_d    <= c8s;
    end
  end

  // Clock FSM next state and next CLKOUT level
  always_comb begin
    st_nx  = st;
    clk_nx = clk_q;
    unique case (st)
      FAST: begin
        clk_nx = fclk;
        if (want_slow) st_nx = TO_SLOW;
      end
      TO_SLOW: begin
        clk_nx = clk_q & fclk;
        if (!clk_q && c8_fall) st_nx = SLOWST;
      end
      SLOWST: begin
        clk_nx = c8s;
        if (!want_slow) st_nx = TO_FAST;
      end
      TO_FAST: begin
        clk_nx = clk_q & c8s;
        if (!clk_q && fclk_fall) st_nx = FAST;
      end
      default: begin
        st_nx  = FAST;
        clk_nx = 1'b0;
      end
    endcase
  end

  // Clock FSM state and registered outputs
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      st     <= FAST;
      clk_q  <= 1'b0;
      slow_q <= 1'b0;
    end else begin
      st     <= st_nx;
      clk_q  <= clk_nx;
      slow_q <= (st_nx == SLOWST) || (st_nx == TO_FAST);
    end
  end

  assign CLKOUT = clk_q;
  assign SLOW   = slow_q;

endmodule

// File: rtl/altram_ctrl_mw.sv
// Alt-RAM glue: window/ROM-shadow decode, SDRAM request, DTACK, commands.
// Define ROM_WP_EN to make shadowed ROM writes acknowledge-and-discard.
module altram_ctrl_mw
  import altram_pkg::*;
#(
  parameter int          NWIN        = 4,
  parameter int          FAST_DIV    = 2,
  parameter int          SYNC_STAGES = 3,
  parameter logic [3:0]  ROM_BANK    = ROM_BANK_DEF,
  parameter logic [19:0] CTRL_BASE   = CTRL_BASE_DEF
) (
  input  logic            CLKOSC,
  input  logic            RST,
  input  logic            AS_N,
  input  logic            RW,
  input  logic [23:1]     A,
  input  logic            BGK_N,
  input  logic            CLK8,
  input  logic            SDRAM_VALID_N,
  output logic            SDRAM_REQ_N,
  output logic [3:0]      RA,
  output logic            DTACK_INT_N,
  output logic            MB_AS_N,
  output logic            SLOW,
  output logic            CLKOUT,
  output logic [NWIN-1:0] WIN_EN
);

  logic [1:0]      as_sync;
  logic [1:0]      bgk_sync;
  logic            as_s;
  logic            bgk_s;
  logic            as_d;
  logic            as_fall;
  logic [23:1]     cyc_a;
  logic            cyc_rw;
  logic            win_hit;
  logic            rom_hit;
  logic            ctrl_hit;
  logic [2:0]      cmd;
  bus_st_t         st;
  bus_st_t         st_nx;
  logic            req_n;
  logic            dtack_n;
  logic            pass_q;
  logic [NWIN-1:0] win_en;
  logic            shadow_on;
  logic            allow_fast;
  logic            want_slow;

  assign as_s    = as_sync[1];
  assign bgk_s   = bgk_sync[1];
  assign as_fall = as_d & ~as_s;
  assign cmd     = cyc_a[3:1];

  // Two-flop synchronisers for the CPU strobes
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      as_sync  <= 2'b11;
      bgk_sync <= 2'b11;
      as_d     <= 1'b1;
    end else begin
      as_sync  <= {as_sync[0], AS_N};
      bgk_sync <= {bgk_sync[0], BGK_N};
      as_d     <= as_s;
    end
  end

  // Latch address and direction when a cycle is accepted
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      cyc_a  <= '0;
      cyc_rw <= 1'b1;
    end else if (st == IDLE && st_nx == DECODE) begin
      cyc_a  <= A;
      cyc_rw <= RW;
    end
  end

  // Window hit: region k (1..NWIN) maps to WIN_EN[k-1]
  always_comb begin
    win_hit = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      if (int'(cyc_a[23:22]) == i + 1) win_hit = win_en[i];
    end
  end

  assign rom_hit  = shadow_on &
                    ((cyc_a[23:20] == 4'hE) || (cyc_a[23:3] == 21'd0));
  assign ctrl_hit = (cyc_a[23:5] == CTRL_BASE[19:1]);
  assign RA       = rom_hit ? ROM_BANK : cyc_a[23:20];

  // Bus FSM next state
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: begin
        if (as_fall && bgk_s) st_nx = DECODE;
      end
      DECODE: begin
        if (as_s) st_nx = IDLE;
        else if (ctrl_hit) st_nx = CTRL;
`ifdef ROM_WP_EN
        else if (rom_hit && !cyc_rw) st_nx = HOLD;
`endif
        else if (win_hit || rom_hit) st_nx = SDRAM;
        else st_nx = PASS;
      end
      SDRAM: begin
        if (as_s) st_nx = IDLE;
        else if (!SDRAM_VALID_N) st_nx = HOLD;
      end
      CTRL: begin
        st_nx = as_s ? IDLE : HOLD;
      end
      PASS: begin
        if (as_s) st_nx = IDLE;
      end
      HOLD: begin
        if (as_s) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // Bus FSM state and registered strobes
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      st      <= IDLE;
      req_n   <= 1'b1;
      dtack_n <= 1'b1;
      pass_q  <= 1'b0;
    end else begin
      st      <= st_nx;
      req_n   <= (st_nx != SDRAM);
      dtack_n <= !((st_nx == CTRL) || (st_nx == HOLD));
      pass_q  <= (st_nx == PASS);
    end
  end

  // Command page: the access itself is the command, run once in CTRL
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      win_en     <= '1;
      shadow_on  <= 1'b0;
      allow_fast <= 1'b1;
    end else if (st == CTRL) begin
      if (cyc_a[4]) begin
        for (int i = 0; i < NWIN; i++) begin
          if (int'(cmd) == i + 1) win_en[i] <= ~cyc_rw;
        end
      end else begin
        unique case (1'b1)
          (cmd == CMD_SHADOW): shadow_on  <= 1'b1;
          (cmd == CMD_FAST):   allow_fast <= 1'b1;
          (cmd == CMD_SLOW):   allow_fast <= 1'b0;
          default:             win_en     <= '0;
        endcase
      end
    end
  end

  assign want_slow = ~allow_fast | ~bgk_s | pass_q;

  clk_switch #(
    .FAST_DIV    (FAST_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_clk (
    .CLKOSC    (CLKOSC),
    .RST       (RST),
    .CLK8      (CLK8),
    .want_slow (want_slow),
    .CLKOUT    (CLKOUT),
    .SLOW      (SLOW)
  );

  assign SDRAM_REQ_N = req_n;
  assign DTACK_INT_N = dtack_n;
  assign MB_AS_N     = pass_q ? AS_N : 1'b1;
  assign WIN_EN      = win_en;

endmodule

// File: tb/tb_altram_ctrl_mw.sv
// Directed bench for altram_ctrl_mw.
// Hand-computed expectations for decode, commands, clock switch, abort.
module tb_altram_ctrl_mw;

  localparam int NWIN     = 4;
  localparam int FAST_DIV = 2;

  logic            CLKOSC = 1'b0;
  logic            RST = 1'b0;
  logic            AS_N = 1'b1;
  logic            RW = 1'b1;
  logic [23:1]     A = '0;
  logic            BGK_N = 1'b1;
  logic            CLK8 = 1'b0;
  logic            SDRAM_VALID_N = 1'b1;
  logic            SDRAM_REQ_N;
  logic [3:0]      RA;
  logic            DTACK_INT_N;
  logic            MB_AS_N;
  logic            SLOW;
  logic            CLKOUT;
  logic [NWIN-1:0] WIN_EN;

  int n_cmp = 0;
  int n_bad = 0;
  int hi;
  int lo;

  int   run_len = 0;
  int   min_pulse = 1000;
  logic prev_clk = 1'b0;
  bit   seen = 1'b0;

  altram_ctrl_mw #(.NWIN(NWIN), .FAST_DIV(FAST_DIV)) dut (
    .CLKOSC        (CLKOSC),
    .RST           (RST),
    .AS_N          (AS_N),
    .RW            (RW),
    .A             (A),
    .BGK_N         (BGK_N),
    .CLK8          (CLK8),
    .SDRAM_VALID_N (SDRAM_VALID_N),
    .SDRAM_REQ_N   (SDRAM_REQ_N),
    .RA            (RA),
    .DTACK_INT_N   (DTACK_INT_N),
    .MB_AS_N       (MB_AS_N),
    .SLOW          (SLOW),
    .CLKOUT        (CLKOUT),
    .WIN_EN        (WIN_EN)
  );

  initial forever #5 CLKOSC = ~CLKOSC;

  initial begin
    #3;
    forever #40 CLK8 = ~CLK8;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no summary after 500us");
    $fatal(1);
  end

  always @(negedge CLKOSC) begin
    if (!RST) begin
      seen     <= 1'b0;
      run_len  <= 0;
      prev_clk <= 1'b0;
    end else if (CLKOUT !== prev_clk) begin
      if (seen && run_len < min_pulse) min_pulse <= run_len;
      seen     <= 1'b1;
      run_len  <= 1;
      prev_clk <= CLKOUT;
    end else begin
      run_len <= run_len + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLKOSC);
      #1;
    end
  endtask

  task automatic start(input logic [23:0] addr, input logic rw);
    A    = addr[23:1];
    RW   = rw;
    AS_N = 1'b0;
  endtask

  task automatic finish();
    AS_N = 1'b1;
    tick(4);
    RW = 1'b1;
  endtask

  task automatic sdram_done();
    SDRAM_VALID_N = 1'b0;
    tick(1);
    SDRAM_VALID_N = 1'b1;
    finish();
  endtask

  task automatic wait_slow(input string tag, input logic want);
    int n;
    n = 0;
    while (SLOW !== want && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, SLOW, want);
  endtask

  task automatic measure(output int h, output int l);
    int n;
    n = 0;
    while (CLKOUT !== 1'b1 && n < 40) begin tick(1); n++; end
    while (CLKOUT !== 1'b0 && n < 80) begin tick(1); n++; end
    while (CLKOUT !== 1'b1 && n < 120) begin tick(1); n++; end
    h = 0;
    while (CLKOUT === 1'b1 && h < 40) begin tick(1); h++; end
    l = 0;
    while (CLKOUT === 1'b0 && l < 40) begin tick(1); l++; end
  endtask

  initial begin
    tick(2);
    check("rst_req", SDRAM_REQ_N, 1);
    check("rst_dtack", DTACK_INT_N, 1);
    check("rst_mbas", MB_AS_N, 1);
    check("rst_slow", SLOW, 0);
    check("rst_clkout", CLKOUT, 0);
    check("rst_win", WIN_EN, 4'hF);
    check("rst_ra", RA, 0);
    RST = 1'b1;
    tick(3);

    start(24'h400000, 1'b1);
    tick(3);
    check("t1_decode_req", SDRAM_REQ_N, 1);
    tick(1);
    check("t1_req", SDRAM_REQ_N, 0);
    check("t1_ra", RA, 4'h4);
    check("t1_mbas", MB_AS_N, 1);
    check("t1_dtack_wait", DTACK_INT_N, 1);
    tick(1);
    SDRAM_VALID_N = 1'b0;
    tick(1);
    check("t1_dtack", DTACK_INT_N, 0);
    SDRAM_VALID_N = 1'b1;
    AS_N = 1'b1;
    tick(2);
    check("t1_dtack_hold", DTACK_INT_N, 0);
    tick(1);
    check("t1_dtack_off", DTACK_INT_N, 1);
    tick(1);

    start(24'hFFFE12, 1'b0);
    tick(5);
    check("t2_en_dtack", DTACK_INT_N, 0);
    check("t2_en_req", SDRAM_REQ_N, 1);
    check("t2_en_win", WIN_EN, 4'hF);
    finish();
    start(24'hFFFE12, 1'b1);
    tick(5);
    check("t2_dis1_win", WIN_EN, 4'hE);
    finish();
    start(24'hFFFE18, 1'b1);
    tick(5);
    check("t2_dis4_win", WIN_EN, 4'h6);
    finish();
    start(24'hFFFE10, 1'b1);
    tick(5);
    check("t2_idx0_dtack", DTACK_INT_N, 0);
    check("t2_idx0_win", WIN_EN, 4'h6);
    finish();
    start(24'hFFFE1A, 1'b0);
    tick(5);
    check("t2_idx5_dtack", DTACK_INT_N, 0);
    check("t2_idx5_win", WIN_EN, 4'h6);
    finish();

    start(24'h400000, 1'b1);
    tick(4);
    check("t2_pass_mbas", MB_AS_N, 0);
    check("t2_pass_req", SDRAM_REQ_N, 1);
    wait_slow("t2_pass_slow", 1'b1);
    check("t2_pass_dtack", DTACK_INT_N, 1);
    AS_N = 1'b1;
    #1;
    check("t2_pass_mbas_up", MB_AS_N, 1);
    tick(4);
    wait_slow("t2_pass_fast", 1'b0);

    start(24'hFFFE12, 1'b0);
    tick(5);
    check("t2_re1_win", WIN_EN, 4'h7);
    finish();
    start(24'hFFFE18, 1'b0);
    tick(5);
    check("t2_re4_win", WIN_EN, 4'hF);
    finish();

    start(24'h000004, 1'b1);
    tick(4);
    check("t3_lo_noshadow_req", SDRAM_REQ_N, 1);
    check("t3_lo_noshadow_mbas", MB_AS_N, 0);
    finish();
    wait_slow("t3_lo_fast", 1'b0);
    start(24'hE01234, 1'b1);
    tick(4);
    check("t3_e_noshadow_req", SDRAM_REQ_N, 0);
    check("t3_e_noshadow_ra", RA, 4'hE);
    sdram_done();
    start(24'hFFFE0E, 1'b1);
    tick(5);
    check("t3_shadow_dtack", DTACK_INT_N, 0);
    finish();
    start(24'hE01234, 1'b1);
    tick(4);
    check("t3_e_req", SDRAM_REQ_N, 0);
    check("t3_e_ra", RA, 4'hB);
    sdram_done();
    start(24'h000004, 1'b1);
    tick(4);
    check("t3_lo_req", SDRAM_REQ_N, 0);
    check("t3_lo_ra", RA, 4'hB);
    sdram_done();
    start(24'hE00000, 1'b0);
    tick(4);
`ifdef ROM_WP_EN
    check("t3_wp_req", SDRAM_REQ_N, 1);
    check("t3_wp_dtack", DTACK_INT_N, 0);
    finish();
`else
    check("t3_wr_req", SDRAM_REQ_N, 0);
    check("t3_wr_ra", RA, 4'hB);
    sdram_done();
`endif

    measure(hi, lo);
    check("t4_fast_hi", hi, FAST_DIV);
    check("t4_fast_lo", lo, FAST_DIV);
    start(24'hFFFE0A, 1'b1);
    tick(5);
    finish();
    wait_slow("t4_slow", 1'b1);
    measure(hi, lo);
    check("t4_slow_hi", hi, 4);
    check("t4_slow_lo", lo, 4);
    start(24'hFFFE0C, 1'b1);
    tick(5);
    finish();
    wait_slow("t4_back_fast", 1'b0);
    measure(hi, lo);
    check("t4_back_hi", hi, FAST_DIV);
    check("t4_back_lo", lo, FAST_DIV);

    start(24'h400000, 1'b1);
    tick(4);
    check("t5_req", SDRAM_REQ_N, 0);
    tick(2);
    AS_N = 1'b1;
    tick(3);
    check("t5_abort_req", SDRAM_REQ_N, 1);
    tick(1);
    SDRAM_VALID_N = 1'b0;
    tick(2);
    check("t5_late_valid", DTACK_INT_N, 1);
    SDRAM_VALID_N = 1'b1;
    tick(2);
    check("t5_late_valid2", DTACK_INT_N, 1);

    BGK_N = 1'b0;
    tick(3);
    start(24'h400000, 1'b1);
    tick(6);
    check("t6_bg_req", SDRAM_REQ_N, 1);
    check("t6_bg_dtack", DTACK_INT_N, 1);
    check("t6_bg_mbas", MB_AS_N, 1);
    wait_slow("t6_bg_slow", 1'b1);
    AS_N = 1'b1;
    tick(4);
    BGK_N = 1'b1;
    tick(3);
    start(24'h400000, 1'b1);
    tick(4);
    check("t6_mid_req", SDRAM_REQ_N, 0);
    BGK_N = 1'b0;
    tick(2);
    SDRAM_VALID_N = 1'b0;
    tick(1);
    check("t6_mid_dtack", DTACK_INT_N, 0);
    SDRAM_VALID_N = 1'b1;
    finish();
    BGK_N = 1'b1;
    tick(3);

    check("t4_min_pulse", min_pulse >= FAST_DIV, 1);

    start(24'hFFFE02, 1'b1);
    tick(5);
    check("t7_clear_win", WIN_EN, 4'h0);
    check("t7_hold_dtack", DTACK_INT_N, 0);
    RST = 1'b0;
    #1;
    check("t7_rst_dtack", DTACK_INT_N, 1);
    check("t7_rst_win", WIN_EN, 4'hF);
    check("t7_rst_req", SDRAM_REQ_N, 1);
    check("t7_rst_slow", SLOW, 0);
    check("t7_rst_clkout", CLKOUT, 0);
    AS_N = 1'b1;
    tick(2);
    RST = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
